// File: rtl/sram_axi_port.sv
// SRAM-like request port to single-beat AXI3 read/write bridge.
// One outstanding transaction; the AW and W channels complete independently.
module sram_axi_port #(
  parameter int unsigned IDW   = 4,
  parameter int unsigned RD_ID = 0,
  parameter int unsigned WR_ID = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req,
  input  logic           wr,
  input  logic [1:0]     size,
  input  logic [31:0]    addr,
  input  logic [3:0]     wstrb,
  input  logic [31:0]    wdata,
  output logic           addr_ok,
  output logic           data_ok,
  output logic [31:0]    rdata,
  output logic [IDW-1:0] arid,
  output logic [31:0]    araddr,
  output logic [2:0]     arsize,
  output logic           arvalid,
  input  logic           arready,
  input  logic [31:0]    rdata_axi,
  input  logic           rvalid,
  output logic           rready,
  output logic [IDW-1:0] awid,
  output logic [31:0]    awaddr,
  output logic [2:0]     awsize,
  output logic           awvalid,
  input  logic           awready,
  output logic [31:0]    wdata_axi,
  output logic [3:0]     wstrb_axi,
  output logic           wvalid,
  input  logic           wready,
  input  logic           bvalid,
  output logic           bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic [3:0]  lat_wstrb;
  logic        aw_done, w_done;
  logic        aw_fin, w_fin;

  // Channel valids/readys are pure decodes of the state and completion flags.
  assign addr_ok = (state == IDLE) & req;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);
  assign awvalid = (state == WR_REQ) & ~aw_done;
  assign wvalid  = (state == WR_REQ) & ~w_done;
  assign bready  = (state == WR_RESP);

  // A channel counts as finished if it already handshook or does so this cycle.
  assign aw_fin = aw_done | (awvalid & awready);
  assign w_fin  = w_done  | (wvalid  & wready);

  assign arid      = IDW'(RD_ID);
  assign awid      = IDW'(WR_ID);
  assign araddr    = lat_addr;
  assign awaddr    = lat_addr;
  assign arsize    = {1'b0, lat_size};
  assign awsize    = {1'b0, lat_size};
  assign wdata_axi = lat_wdata;
  assign wstrb_axi = lat_wstrb;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = wr ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_next = RD_DATA;
      RD_DATA: if (rvalid) state_next = IDLE;
      WR_REQ:  if (aw_fin & w_fin) state_next = WR_RESP;
      WR_RESP: if (bvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, completion pulse, read data and write-channel flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_size  <= '0;
      lat_wstrb <= '0;
      rdata     <= '0;
      data_ok   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      data_ok <= ((state == RD_DATA) & rvalid) | ((state == WR_RESP) & bvalid);
      if (addr_ok) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_wstrb <= wstrb;
        lat_size  <= (size == 2'd3) ? 2'd2 : size;
      end
      if ((state == RD_DATA) && rvalid) rdata <= rdata_axi;
      if ((state == WR_REQ) && !(aw_fin && w_fin)) begin
        aw_done <= aw_fin;
        w_done  <= w_fin;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_axi_port.sv
// Self-checking bench for sram_axi_port: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_sram_axi_port;
  localparam int unsigned IDW   = 4;
  localparam int unsigned RD_ID = 0;
  localparam int unsigned WR_ID = 1;

  logic           clk = 1'b0;
  logic           reset, req, wr;
  logic [1:0]     size;
  logic [31:0]    addr, wdata, rdata, araddr, awaddr, rdata_axi, wdata_axi;
  logic [3:0]     wstrb, wstrb_axi;
  logic           addr_ok, data_ok, arvalid, arready, rvalid, rready;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic [IDW-1:0] arid, awid;
  logic [2:0]     arsize, awsize;

  sram_axi_port #(.IDW(IDW), .RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .arid(arid), .araddr(araddr), .arsize(arsize),
    .arvalid(arvalid), .arready(arready), .rdata_axi(rdata_axi),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
    .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what is outstanding and which channels have handshaken.
  bit          m_busy = 0, m_wr = 0, m_ar = 0, m_aw = 0, m_w = 0, m_done = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [1:0]  m_size = '0;
  logic [3:0]  m_wstrb = '0;
  bit          e_arvalid, e_rready, e_awvalid, e_wvalid, e_bready;

  task automatic model_check();
    e_arvalid = m_busy && !m_wr && !m_ar;
    e_rready  = m_busy && !m_wr && m_ar;
    e_awvalid = m_busy && m_wr && !m_aw;
    e_wvalid  = m_busy && m_wr && !m_w;
    e_bready  = m_busy && m_wr && m_aw && m_w;
    chk("addr_ok", addr_ok, 32'(!m_busy && req));
    chk("data_ok", data_ok, 32'(m_done));
    chk("rdata", rdata, m_rdata);
    chk("arvalid", arvalid, 32'(e_arvalid));
    chk("rready", rready, 32'(e_rready));
    chk("awvalid", awvalid, 32'(e_awvalid));
    chk("wvalid", wvalid, 32'(e_wvalid));
    chk("bready", bready, 32'(e_bready));
    chk("ar_aw_exclusive", 32'(arvalid & awvalid), 32'd0);
    chk("ids", {arid, awid}, 32'((RD_ID << IDW) | WR_ID));
    if (e_arvalid) begin
      chk("araddr", araddr, m_addr);
      chk("arsize", arsize, 32'(m_size));
    end
    if (e_awvalid) begin
      chk("awaddr", awaddr, m_addr);
      chk("awsize", awsize, 32'(m_size));
    end
    if (e_wvalid) begin
      chk("wdata_axi", wdata_axi, m_wdata);
      chk("wstrb_axi", wstrb_axi, 32'(m_wstrb));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_busy = 0; m_done = 0; m_rdata = '0;
      m_ar = 0; m_aw = 0; m_w = 0;
      return;
    end
    m_done = 0;
    if (m_busy) begin
      if (!m_wr) begin
        if (e_rready && rvalid) begin m_rdata = rdata_axi; m_done = 1; m_busy = 0; end
        if (e_arvalid && arready) m_ar = 1;
      end else begin
        if (e_bready && bvalid) begin m_done = 1; m_busy = 0; end
        if (e_awvalid && awready) m_aw = 1;
        if (e_wvalid && wready) m_w = 1;
      end
    end else if (req) begin
      m_busy = 1; m_wr = wr; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
      m_size = (size == 2'd3) ? 2'd2 : size;
      m_ar = 0; m_aw = 0; m_w = 0;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_all(input logic v);
    arready = v; rvalid = v; awready = v; wready = v; bvalid = v;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] axi_rdata;
    logic [2:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'h1C00_0010, 4'h0, 32'h0,          32'hDEAD_BEEF, 3'b010, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_0101, 4'h2, 32'h0000_AB00,  32'h1111_1111, 3'b000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_0202, 4'h0, 32'h0,          32'hCAFE_F00D, 3'b001, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 2'd3, 32'h0000_0300, 4'h0, 32'h0,          32'h0BAD_C0DE, 3'b010, 32'h0BAD_C0DE};
    vecs[4] = '{1'b1, 2'd3, 32'h0000_0400, 4'hF, 32'hA5A5_A5A5,  32'h2222_2222, 3'b010, 32'h0BAD_C0DE};
    vecs[5] = '{1'b0, 2'd0, 32'h0000_0503, 4'h0, 32'h0,          32'h0000_00FF, 3'b000, 32'h0000_00FF};

    reset = 1'b1; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wstrb = '0; wdata = '0;
    rdata_axi = '0;
    slave_all(1'b0);
    model_update();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("reset_data_ok", data_ok, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    adv();
    reset = 1'b0;

    // Zero-wait slave vectors: minimum latency, data_ok on cycle 3.
    slave_all(1'b1);
    foreach (vecs[i]) begin
      rdata_axi = vecs[i].axi_rdata;
      req = 1'b1; wr = vecs[i].wr; size = vecs[i].size; addr = vecs[i].addr;
      wstrb = vecs[i].wstrb; wdata = vecs[i].wdata;
      settle(); chk("vec_addr_ok", addr_ok, 32'd1); adv();
      req = 1'b0;
      settle();
      if (!vecs[i].wr) begin
        chk("vec_arvalid", arvalid, 32'd1);
        chk("vec_araddr", araddr, vecs[i].addr);
        chk("vec_arsize", arsize, 32'(vecs[i].exp_size));
      end else begin
        chk("vec_awvalid_wvalid", {awvalid, wvalid}, 32'd3);
        chk("vec_awsize", awsize, 32'(vecs[i].exp_size));
        chk("vec_wdata", wdata_axi, vecs[i].wdata);
        chk("vec_wstrb", wstrb_axi, 32'(vecs[i].wstrb));
      end
      adv();
      settle();
      chk("vec_early_data_ok", data_ok, 32'd0);
      chk("vec_resp_ready", vecs[i].wr ? bready : rready, 32'd1);
      adv();
      settle();
      chk("vec_data_ok", data_ok, 32'd1);
      chk("vec_rdata", rdata, vecs[i].exp_rdata);
      adv();
      settle(); chk("vec_data_ok_pulse", data_ok, 32'd0); adv();
    end

    // Write with AW at cycle 1, W at cycle 4, B at cycle 6.
    slave_all(1'b0);
    wr = 1'b1; size = 2'd2; addr = 32'h100; wstrb = 4'b0011; wdata = 32'h1234_5678;
    for (int c = 0; c < 9; c++) begin
      req = (c == 0); awready = (c == 1); wready = (c == 4); bvalid = (c == 6);
      settle();
      if (c == 1) chk("split_awsize", awsize, 32'b010);
      if (c >= 2) chk("split_awvalid_low", awvalid, 32'd0);
      if (c >= 1) chk("split_wvalid", wvalid, 32'(c <= 4));
      chk("split_bready", bready, 32'(c == 5 || c == 6));
      chk("split_data_ok", data_ok, 32'(c == 7));
      adv();
    end

    // W handshake before AW; response phase starts at cycle 4.
    slave_all(1'b0);
    addr = 32'h0000_0800; wdata = 32'h0F0F_0F0F; wstrb = 4'b1100;
    for (int c = 0; c < 7; c++) begin
      req = (c == 0); wready = (c == 1); awready = (c == 3); bvalid = (c == 4);
      settle();
      if (c >= 1) chk("wfirst_wvalid", wvalid, 32'(c == 1));
      if (c >= 1) chk("wfirst_awvalid", awvalid, 32'(c <= 3));
      chk("wfirst_bready", bready, 32'(c == 4));
      chk("wfirst_data_ok", data_ok, 32'(c == 5));
      adv();
    end

    // AR stalled for 10 cycles while the CPU keeps requesting.
    slave_all(1'b0);
    wr = 1'b0; size = 2'd1;
    rdata_axi = 32'h7654_3210;
    for (int c = 0; c < 15; c++) begin
      req = (c <= 11);
      addr = (c == 0) ? 32'h2000_0004 : 32'h3000_0000 + 32'(c);
      arready = (c == 11); rvalid = (c == 12);
      settle();
      chk("stall_addr_ok", addr_ok, 32'(c == 0));
      chk("stall_data_ok", data_ok, 32'(c == 13));
      if (c >= 1 && c <= 11) chk("stall_araddr", araddr, 32'h2000_0004);
      adv();
    end

    // Read then write back-to-back with req held high.
    slave_all(1'b1);
    rdata_axi = 32'h5555_AAAA; size = 2'd2; addr = 32'h0000_0040; wstrb = 4'hF; wdata = 32'h9999_0000;
    for (int c = 0; c < 8; c++) begin
      req = (c <= 3); wr = (c > 0);
      settle();
      chk("b2b_addr_ok", addr_ok, 32'(c == 0 || c == 3));
      chk("b2b_data_ok", data_ok, 32'(c == 3 || c == 6));
      if (c == 3) chk("b2b_rdata", rdata, 32'h5555_AAAA);
      adv();
    end

    // Reset while waiting in the read-data phase.
    slave_all(1'b0);
    wr = 1'b0; addr = 32'h0000_0C00; rdata_axi = 32'h1357_9BDF;
    for (int c = 0; c < 9; c++) begin
      req = (c == 0 || c == 4); reset = (c == 2);
      arready = (c == 1 || c >= 5); rvalid = (c >= 6);
      settle();
      if (c == 2) chk("rst_in_rd_data", rready, 32'd1);
      if (c == 3) begin
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, data_ok}, 32'd0);
      end
      chk("rst_addr_ok", addr_ok, 32'(c == 0 || c == 4));
      chk("rst_data_ok", data_ok, 32'(c == 7));
      adv();
    end
    reset = 1'b0;

    // Randomized traffic and slave timing, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      req       = ($urandom_range(0, 2) != 0);
      wr        = 1'($urandom_range(0, 1));
      size      = 2'($urandom_range(0, 3));
      addr      = $urandom();
      wstrb     = 4'($urandom_range(0, 15));
      wdata     = $urandom();
      rdata_axi = $urandom();
      arready   = 1'($urandom_range(0, 1));
      rvalid    = 1'($urandom_range(0, 1));
      awready   = 1'($urandom_range(0, 1));
      wready    = 1'($urandom_range(0, 1));
      bvalid    = 1'($urandom_range(0, 1));
      settle();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_port.md
Name: sram_axi_port

Overview:
- Downstream of the CPU core's data-memory interface.
- Converts one SRAM-like request port (req/addr_ok/data_ok) into single-beat AXI3 read and write transactions. There is one outstanding transaction at a time.
- Sits between the core's data side and the system AXI interconnect. A second instance serves the instruction side.
- AXI fields not listed below (len=0, burst=INCR, lock, cache, prot) are tied to constants by the enclosing wrapper.

Parameters:
- IDW, 4, width of arid/awid.
- RD_ID, 0, value driven on arid.
- WR_ID, 1, value driven on awid.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as 2).
- addr  in  32  byte address.
- wstrb  in  4  write byte enables.
- wdata  in  32  write data.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  transaction complete, one-cycle pulse.
- rdata  out  32  read data, valid when data_ok follows a read.
- arid  out  IDW  constant RD_ID.
- araddr  out  32  read address.
- arsize  out  3  {1'b0, size}.
- arvalid  out  1  read address valid.
- arready  in  1  slave accepts AR.
- rdata_axi  in  32  AXI read data.
- rvalid  in  1  read data valid.
- rready  out  1  bridge accepts R.
- awid  out  IDW  constant WR_ID.
- awaddr  out  32  write address.
- awsize  out  3  {1'b0, size}.
- awvalid  out  1  write address valid.
- awready  in  1  slave accepts AW.
- wdata_axi  out  32  write data.
- wstrb_axi  out  4  write strobes.
- wvalid  out  1  write data valid (wlast tied 1 by wrapper).
- wready  in  1  slave accepts W.
- bvalid  in  1  write response valid.
- bready  out  1  bridge accepts B.

Behaviour:
- Reset (reset=1 at posedge):
  - state = IDLE.
  - arvalid, rready, awvalid, wvalid, bready, data_ok all 0; rdata = 0; all latched request fields = 0.
  - Reset mid-transaction abandons it silently; the AXI slave is reset together with the bridge.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - addr_ok = req, combinational; it is asserted only in IDLE, 0 in every other state.
  - On req & addr_ok, latch wr/size/addr/wstrb/wdata, mapping size 3 to 2. Then go to WR_REQ if wr, else RD_ADDR.
- RD_ADDR:
  - arvalid = 1; araddr and arsize are driven from the latched fields and held stable.
  - On arready, go to RD_DATA; arvalid is 0 from the next cycle.
- RD_DATA:
  - rready = 1.
  - On rvalid, register rdata <= rdata_axi and data_ok <= 1 for exactly one cycle, then go to IDLE.
  - rresp is ignored.
  - rdata holds its value until the next read completes.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry.
  - Each clears independently after its own handshake; internal flags aw_done and w_done record completion.
  - Both handshakes may land in the same cycle, in either order, or separated by any number of cycles.
  - Go to WR_RESP on the edge where both are done. Clear the flags on exit.
- WR_RESP:
  - bready = 1.
  - On bvalid, data_ok <= 1 for one cycle, then go to IDLE.
  - rdata is unchanged.
- Back-to-back requests:
  - The cycle data_ok is high, the bridge is already in IDLE. A new req is accepted (addr_ok = 1) in that same cycle.
- Minimum read latency (zero-wait slave):
  - Accept at cycle 0, AR handshake at cycle 1, R at cycle 2, data_ok at cycle 3.
- Minimum write latency (zero-wait slave):
  - AW and W handshake at cycle 1, B at cycle 2, data_ok at cycle 3.
- The bridge never asserts arvalid and awvalid simultaneously.
- wready/awready received before the corresponding valid have no effect.

Test Plan:
- Read, zero-wait slave: req=1, wr=0, addr=0x1C000010, size=2 at cycle 0. Expect addr_ok=1 at cycle 0, arvalid with araddr=0x1C000010 and arsize=3'b010 at cycle 1. Slave returns 0xDEADBEEF at cycle 2; expect data_ok=1 and rdata=0xDEADBEEF at cycle 3 only.
- Write, split handshakes: wr=1, addr=0x100, wstrb=4'b0011, wdata=0x12345678. Slave gives awready at cycle 1, wready at cycle 4, bvalid at cycle 6. Expect:
  - awvalid low from cycle 2; wvalid high cycles 1–4.
  - bready high from cycle 5.
  - data_ok at cycle 7; awsize=3'b010.
- W before AW: wready at cycle 1, awready at cycle 3. Expect WR_RESP entered at cycle 4 and no second W beat.
- Back-to-back: hold req=1 across a read then a write. Expect the second addr_ok in the same cycle as the first data_ok, and arvalid/awvalid never high together.
- Stall: arready held 0 for 10 cycles. Expect araddr stable, addr_ok=0 while busy, data_ok=0 throughout.
- Reset mid-read: assert reset while in RD_DATA. Expect all valids/readys = 0, data_ok = 0 and rdata = 0 at the next cycle, and a fresh req accepted one cycle after reset deasserts.
